// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial W-bit adder controller.
// One shared 1-bit full adder cell is used W times, LSB first. The carry is
// registered between bits. The partial sum is collected in a shift register.
// When the last bit is done, the W-bit sum and the carry-out are loaded into
// the output registers and done pulses for one cycle.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' input.
// With sub=1 the block computes a - b as a + ~b + 1.
module serial_adder_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         co
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   psum_q;
    logic           carry_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   sum_q;
    logic           co_q;
    logic           ready_q;
    logic           busy_q;
    logic           done_q;

    logic           cell_s;
    logic           cell_c;
    logic [W-1:0]   psum_d;
    logic [W-1:0]   b_load_d;
    logic           cin_load_d;

    // Shared full adder cell. It works on the LSBs of the operand shift registers.
    always_comb begin
        cell_s = a_q[0] ^ b_q[0] ^ carry_q;
        cell_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        psum_d = {cell_s, psum_q[W-1:1]};
    end

    // Values loaded at accept time. Subtraction stores ~b and starts with carry 1.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load_d   = sub ? ~b : b;
        cin_load_d = sub;
    end
`else
    always_comb begin
        b_load_d   = b;
        cin_load_d = 1'b0;
    end
`endif

    // Controller FSM. The datapath registers and the status outputs are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load_d;
                        carry_q <= cin_load_d;
                        cnt_q   <= '0;
                        psum_q  <= '0;
                        state_q <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    a_q     <= {1'b0, a_q[W-1:1]};
                    b_q     <= {1'b0, b_q[W-1:1]};
                    psum_q  <= psum_d;
                    carry_q <= cell_c;
                    if (cnt_q == LAST_BIT) begin
                        // The last bit is done: publish the result and its carry-out.
                        sum_q   <= psum_d;
                        co_q    <= cell_c;
                        cnt_q   <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign co    = co_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl with W=8.
// It uses directed and randomized operations. Expected results come from plain
// arithmetic on the operands.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;

    int checks = 0;
    int errors = 0;

    // Reference state: the last published result.
    logic [W-1:0] exp_sum;
    logic         exp_co;

    serial_adder_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one operation. Call it at a negedge. It returns at the negedge after
    // DONE, with the controller back in IDLE.
    // hold: keep start high so the next call is accepted right away.
    // poke: pulse start during RUN/DONE. Those pulses must be ignored.
    task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic ss, input bit hold, input bit poke);
        int n;
        logic [W:0] full;
        logic [W-1:0] r_sum;
        logic         r_co;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", {31'd0, ready}, 32'd1);
        if (ss) begin
            r_sum = aa - bb;
            r_co  = (aa >= bb);
        end else begin
            full  = {1'b0, aa} + {1'b0, bb};
            r_sum = full[W-1:0];
            r_co  = full[W];
        end
        a = aa;
        b = bb;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ss;
`endif
        start = 1'b1;
        @(negedge clk);
        // The operands are latched now. Later changes must have no effect.
        a = W'($urandom);
        b = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        start = hold;
        for (int k = 0; k < W; k++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            check("sum_held_run", {24'd0, sum}, {24'd0, exp_sum});
            if (poke && !hold) start = 1'($urandom);
            @(negedge clk);
        end
        exp_sum = r_sum;
        exp_co  = r_co;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("ready_in_done", {31'd0, ready}, 32'd0);
        check("sum", {24'd0, sum}, {24'd0, exp_sum});
        check("co", {31'd0, co}, {31'd0, exp_co});
        if (poke && !hold) start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("done_fell", {31'd0, done}, 32'd0);
        check("ready_after", {31'd0, ready}, 32'd1);
        check("sum_held_after", {24'd0, sum}, {24'd0, exp_sum});
        check("co_held_after", {31'd0, co}, {31'd0, exp_co});
        $display("op a=%02h b=%02h sub=%0d -> sum=%02h co=%0d", aa, bb, ss, sum, co);
    endtask

    initial begin
        bit saw_done;
        logic rs;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        exp_sum = '0;
        exp_co  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_co", {31'd0, co}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations.
        do_op(8'h3C, 8'h15, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        do_op(8'h07, 8'h09, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        a = 8'h3C;
        b = 8'h15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_sum = '0;
        exp_co  = 1'b0;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_sum", {24'd0, sum}, 32'd0);
        check("midrst_co", {31'd0, co}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", {31'd0, saw_done}, 32'd0);
        $display("reset mid-op: sum=%02h done_seen=%0d", sum, saw_done);
        do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
        do_op(8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
        do_op(8'h55, 8'h55, 1'b1, 1'b0, 1'b0);
`endif

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), rs, 1'($urandom_range(0, 3) == 0),
                  1'($urandom));
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
